// File: rtl/sub_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sub_arbiter
// Description : Two-requester round-robin arbiter in front of one shared
//               subtractor. Produces a registered difference with zero,
//               overflow/borrow and negative/less-than flags, tagged with the
//               id of the requester that owns it. Valid/ready output handshake
//               with full throughput and backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module sub_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [1:0]       sign,
  output logic [1:0]       gnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_z,
  output logic             out_v,
  output logic             out_n,
  output logic             out_id
);

  localparam int c_msb = WIDTH - 1;

  logic             r_prio;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_s;
  logic             r_out_z;
  logic             r_out_v;
  logic             r_out_n;
  logic             r_out_id;

  logic             w_can_accept;
  logic [1:0]       w_gnt;
  logic             w_fire;
  logic             w_sel;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_signed;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_s;
  logic             w_borrow;
  logic             w_sovf;
  logic             w_z;
  logic             w_v;
  logic             w_n;

  // The output register can take a new result if it is empty or being drained.
  assign w_can_accept = !r_out_valid | out_ready;

  // Grant selection: sole requester wins, ties go to the round-robin pointer.
  always_comb begin
    w_gnt = 2'b00;
    if (!reset && w_can_accept) begin
      case (req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_prio ? 2'b10 : 2'b01;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  assign gnt    = w_gnt;
  assign w_fire = |w_gnt;
  assign w_sel  = w_gnt[1];

  // Operand mux feeding the single shared subtractor.
  assign w_a      = w_sel ? a1 : a0;
  assign w_b      = w_sel ? b1 : b0;
  assign w_signed = w_sel ? sign[1] : sign[0];

  // Widened subtract: the extra top bit is the unsigned borrow.
  assign w_diff   = {1'b0, w_a} - {1'b0, w_b};
  assign w_s      = w_diff[c_msb:0];
  assign w_borrow = w_diff[WIDTH];

  // Two's complement overflow: operands differ in sign and result sign flips.
  assign w_sovf = (w_a[c_msb] != w_b[c_msb]) & (w_s[c_msb] != w_a[c_msb]);

  // Flag selection per mode; signed less-than is sign XOR overflow.
  always_comb begin
    w_z = (w_s == '0);
    w_v = w_borrow;
    w_n = w_borrow;
    if (w_signed) begin
      w_v = w_sovf;
      w_n = w_s[c_msb] ^ w_sovf;
    end
  end

  // Result register, valid flag and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_s     <= '0;
      r_out_z     <= 1'b0;
      r_out_v     <= 1'b0;
      r_out_n     <= 1'b0;
      r_out_id    <= 1'b0;
    end else if (w_fire) begin
      r_prio      <= ~w_sel;
      r_out_valid <= 1'b1;
      r_out_s     <= w_s;
      r_out_z     <= w_z;
      r_out_v     <= w_v;
      r_out_n     <= w_n;
      r_out_id    <= w_sel;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_s     = r_out_s;
  assign out_z     = r_out_z;
  assign out_v     = r_out_v;
  assign out_n     = r_out_n;
  assign out_id    = r_out_id;

endmodule
`default_nettype wire

// File: doc/sub_arbiter.md
SUB_ARBITER -- requirements
Module: sub_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width; all values below assume 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  2  req[i] = requester i has a subtract pending.
REQ-005 a0, b0  input  32 each  requester 0 operands; the result is a0 - b0.
REQ-006 a1, b1  input  32 each  requester 1 operands; the result is a1 - b1.
REQ-007 sign  input  2  sign[i] = 1 means requester i's operation is signed; 0 means unsigned.
REQ-008 gnt  output  2  one-hot-or-zero grant; the request is accepted in a cycle where req[i] & gnt[i].
REQ-009 out_valid  output  1  the result register holds an unconsumed result.
REQ-010 out_ready  input  1  the consumer accepts the result in a cycle where out_valid & out_ready.
REQ-011 out_s  output  32  registered difference.
REQ-012 out_z, out_v, out_n  output  1 each  registered zero, overflow/borrow and negative/less-than flags.
REQ-013 out_id  output  1  index of the requester that owns the current result.

Function
REQ-014 The block owns one shared subtractor and one output register, and shall serve one operation per cycle at most.
REQ-015 Accept condition: can_accept = !out_valid | out_ready.
REQ-016 gnt shall be combinational from req, prio and can_accept, and shall be zero whenever can_accept = 0.
REQ-017 Only one requester request with can_accept: that requester is granted.
REQ-018 Both request with can_accept: requester prio is granted.
REQ-019 prio is a 1-bit round-robin pointer; after any grant to requester i, prio <= ~i; with no grant, prio holds.
REQ-020 On accept of requester i, next edge: out_s <= a_i - b_i (mod 2^32), out_id <= i, out_valid <= 1; the flags are computed from the same operands (latency 1 cycle).
REQ-021 out_z = (out_s == 0), in both modes.
REQ-022 Unsigned mode: out_n = out_v = (a < b) unsigned, i.e. the borrow.
REQ-023 Signed mode: out_n = (a < b) as two's complement; out_v = (a[31] != b[31]) & (s[31] != a[31]).
REQ-024 out_valid & !out_ready: out_s, the flags, out_id and out_valid shall hold, and gnt = 0 (backpressure).
REQ-025 out_valid & out_ready & no grant: out_valid <= 0 next edge.
REQ-026 out_valid & out_ready & grant: new result loaded with no bubble (full throughput).
REQ-027 Requesters shall hold their operands and sign stable while req is high and no grant has been given; the block samples them only in the grant cycle.
REQ-028 A requester that deasserts req without a grant is dropped silently, with no state change.
REQ-029 Starvation bound: a continuously asserted req is granted within 2 accept opportunities.

Reset
REQ-030 While reset is high at an edge, the next-state values are: out_valid = 0, out_s = 0, out_z = 0, out_v = 0, out_n = 0, out_id = 0, prio = 0; reset takes priority over every other event.
REQ-031 gnt shall be 0 during any cycle in which reset is high.
REQ-032 A result pending at reset is discarded; a request asserted in the reset cycle is not accepted.
REQ-033 After reset deasserts, the block is ready in the first cycle.

Verification
REQ-034 Unsigned borrow: req0, a0 = 5, b0 = 7, sign0 = 0, out_ready = 1 -> next cycle out_valid = 1, out_s = 0xFFFFFFFE, z = 0, n = 1, v = 1, out_id = 0.
REQ-035 Signed overflow: req1, a1 = 0x7FFFFFFF, b1 = 0xFFFFFFFF, sign1 = 1 -> out_s = 0x80000000, v = 1, n = 0, z = 0, out_id = 1; then a1 = 0x80000000, b1 = 1 -> out_s = 0x7FFFFFFF, v = 1, n = 1.
REQ-036 Zero: a0 = b0 = 0x1234, either sign -> z = 1, n = 0, v = 0.
REQ-037 Round-robin: both req held for 4 cycles after reset, out_ready = 1 -> gnt sequence 01, 10, 01, 10; out_id sequence 0, 1, 0, 1, back-to-back with no bubbles.
REQ-038 Backpressure: result valid, out_ready = 0 for 3 cycles with both req high -> gnt = 0 and outputs stable for those 3 cycles; out_ready = 1 -> the pending result is consumed and the next grant is loaded on the same edge.
REQ-039 Reset mid-operation: out_valid = 1, prio = 1, assert reset for 1 cycle -> out_valid = 0 and all outputs 0; the next simultaneous request is granted to requester 0.
